// File: rtl/edge_propagator_tx_cnt.sv
// -----------------------------------------------------------------------------
// edge_propagator_tx_cnt
//
// Source-domain half of a 4-phase clock-domain-crossing event link. Single-cycle
// event pulses on valid_i are queued in a saturating pending counter. Each event
// is delivered to the receive domain as one REQ level on valid_o. valid_o is held
// until the synchronized acknowledge rises, and it is then released. A new
// request is launched only after the acknowledge has been seen low again.
//
// Parameters:
//   CNT_WIDTH   - width of the pending-event counter (max 2^CNT_WIDTH-1 queued)
//   SYNC_STAGES - depth of the ack_i synchronizer (>= 2)
//
// Ports:
//   clk_i      in   block clock
//   rst_i      in   synchronous active-high reset
//   valid_i    in   event pulse, one event per high cycle
//   ack_i      in   acknowledge level from the receive domain (asynchronous)
//   valid_o    out  request level to the receive domain, straight from a flop
//   pending_o  out  events accepted but not yet launched
//   busy_o     out  state is not IDLE or events are pending
//   overflow_o out  one-cycle pulse after an event was dropped
// -----------------------------------------------------------------------------
module edge_propagator_tx_cnt #(
    parameter int CNT_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 ack_i,
    output logic                 valid_o,
    output logic [CNT_WIDTH-1:0] pending_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int                   FLUSH_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(SYNC_STAGES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic [FLUSH_W-1:0]     r_flush;
    logic [FLUSH_W-1:0]     w_flush_nxt;
    logic [CNT_WIDTH-1:0]   r_pending;
    logic [CNT_WIDTH-1:0]   w_pending_nxt;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   w_launch;
    logic                   w_drop;

    // ack_i is only ever sampled by the first synchronizer flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Next-state logic. INIT lets the synchronizer fill with the true ack_i
    // level before RELEASE waits for it to be low, so a stale acknowledge left
    // over from an interrupted handshake can never complete a new request.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush;
        w_launch    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_flush == FLUSH_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_flush_nxt = '0;
                end else begin
                    w_flush_nxt = r_flush + FLUSH_W'(1);
                end
            end
            S_IDLE: begin
                if ((r_pending != '0) || valid_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Pending counter: a same-cycle event and launch cancel out, since the
    // incoming event is the one being launched.
    always_comb begin
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        if (valid_i && !w_launch) begin
            if (r_pending == CNT_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_pending_nxt = r_pending + CNT_WIDTH'(1);
            end
        end else if (!valid_i && w_launch) begin
            w_pending_nxt = r_pending - CNT_WIDTH'(1);
        end
    end

    // valid_o is the registered decode of the next state, so it is glitch-free
    // and rises on the same edge that launches the event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_INIT;
            r_flush    <= '0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flush    <= w_flush_nxt;
            r_pending  <= w_pending_nxt;
            r_valid    <= (w_state_nxt == S_REQ);
            r_overflow <= w_drop;
        end
    end

    assign valid_o    = r_valid;
    assign pending_o  = r_pending;
    assign overflow_o = r_overflow;
    assign busy_o     = (r_state != S_IDLE) || (r_pending != '0);

endmodule
